// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants, S-box table and GF(2^8) helpers
// Contents: word_t, key-schedule FSM state type, NK/NB/NR per key size,
//           SBOX table, sbox() lookup, xtime() GF(2^8) doubling.
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_READY  = 2'd2
    } ks_state_t;

    localparam int AES_NB    = 4;
    localparam int AES128_NK = 4;
    localparam int AES128_NR = 10;
    localparam int AES192_NK = 6;
    localparam int AES192_NR = 12;
    localparam int AES256_NK = 8;
    localparam int AES256_NR = 14;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/sub_word.sv
// rtl/sub_word.sv - four parallel S-box lookups on one 32-bit word
// Ports: word (in, 32) source word; sub (out, 32) byte-wise S-box result.
module sub_word
    import aes_pkg::*;
(
    input  word_t word,
    output word_t sub
);

    assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};

endmodule

// File: rtl/key_schedule_192_seq.sv
// rtl/key_schedule_192_seq.sv - sequential AES-192 key expansion, one word per cycle
// Ports: clk, rst (sync, active-high), start, cipher_key[191:0] (word 0 in MSBs),
//        rk_idx[3:0] round-key select, rk_data[127:0] combinational round key,
//        busy, keys_valid, done (one-cycle pulse when the last word is written).
module key_schedule_192_seq
    import aes_pkg::*;
#(
    parameter int NK = AES192_NK,
    parameter int NB = AES_NB,
    parameter int NR = AES192_NR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [32*NK-1:0]    cipher_key,
    input  logic [3:0]          rk_idx,
    output logic [32*NB-1:0]    rk_data,
    output logic                busy,
    output logic                keys_valid,
    output logic                done
);

    localparam int NW = NB * (NR + 1);

    ks_state_t  state;
    logic [5:0] widx;
    logic [2:0] phase;
    logic [7:0] rcon;
    word_t      w [NW];

    word_t prev_word;
    word_t back_word;
    word_t rot_word;
    word_t sub_rot;
    word_t next_word;

    // Outside EXPAND these indices may point past the array; the result is unused there.
    assign prev_word = w[widx - 6'd1];
    assign back_word = w[widx - 6'(NK)];
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};

    sub_word u_sub_word (
        .word (rot_word),
        .sub  (sub_rot)
    );

    always_comb begin
        next_word = back_word ^ prev_word;
        if (phase == 3'd0) begin
            next_word = back_word ^ sub_rot ^ {rcon, 24'h0};
        end
    end

    // Out-of-range indices are clamped before addressing so the read never leaves the array.
    logic       rk_oob;
    logic [3:0] rk_sel;
    logic [5:0] rk_base;

    assign rk_oob  = (rk_idx > 4'(NR));
    assign rk_sel  = rk_oob ? 4'd0 : rk_idx;
    assign rk_base = {rk_sel, 2'b00};
    assign rk_data = rk_oob ? '0 :
                     {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= KS_IDLE;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            done       <= 1'b0;
            widx       <= 6'd0;
            phase      <= 3'd0;
            rcon       <= 8'h01;
        end else begin
            done <= 1'b0;
            case (state)
                KS_IDLE, KS_READY: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) begin
                            w[k] <= cipher_key[32*(NK-k)-1 -: 32];
                        end
                        widx       <= 6'(NK);
                        phase      <= 3'd0;
                        rcon       <= 8'h01;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= KS_EXPAND;
                    end
                end
                KS_EXPAND: begin
                    w[widx] <= next_word;
                    widx    <= widx + 6'd1;
                    phase   <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                    if (phase == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                    if (widx == 6'(NW - 1)) begin
                        state      <= KS_READY;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                        done       <= 1'b1;
                    end
                end
                default: state <= KS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_schedule_192_seq.sv
// tb/tb_key_schedule_192_seq.sv - directed self-checking bench for key_schedule_192_seq
module tb_key_schedule_192_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [191:0] cipher_key = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] rk_data;
    logic         busy;
    logic         keys_valid;
    logic         done;

    int check_count = 0;
    int pass_count  = 0;

    localparam logic [191:0] KEY_C2 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    always #5 clk = ~clk;

    key_schedule_192_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cipher_key (cipher_key),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_count++;
        if (obs === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
        rk_idx = idx;
        #1;
        val = rk_data;
    endtask

    // Starts an expansion and samples 1 time unit after each following edge.
    // inj_cycle > 0 injects a start (inj_key) or a reset at that sample point.
    task automatic run(input logic [191:0] key, input int inj_cycle, input bit inj_rst,
                       input logic [191:0] inj_key, output int done_cyc, output bit kv_low_first);
        @(negedge clk);
        cipher_key = key;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cyc = -1;
        kv_low_first = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            rst = 1'b0;
            if (n == 1) kv_low_first = !keys_valid;
            if (done && done_cyc < 0) done_cyc = n;
            if (done_cyc >= 0) break;
            if (inj_rst && n == inj_cycle + 1) break;
            if (n == inj_cycle) begin
                if (inj_rst) begin
                    rst = 1'b1;
                end else begin
                    start = 1'b1;
                    cipher_key = inj_key;
                end
            end
        end
    endtask

    task automatic check_c2_keys(input string pfx);
        logic [127:0] v;
        read_rk(4'd0, v);
        check({pfx, "_rk0"}, v, 128'h000102030405060708090a0b0c0d0e0f);
        read_rk(4'd1, v);
        check({pfx, "_rk1"}, v, 128'h10111213141516175846f2f95c43f4fe);
        read_rk(4'd12, v);
        check({pfx, "_rk12"}, v, 128'ha4970a331a78dc09c418c271e3a41d5d);
    endtask

    initial begin
        int           dc;
        bit           kvl;
        logic [127:0] v;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_keys_valid", keys_valid, 0);
        check("reset_done", done, 0);

        // FIPS-197 C.2
        run(KEY_C2, 0, 1'b0, '0, dc, kvl);
        check("c2_done_cycle", dc, 46);
        check("c2_keys_valid", keys_valid, 1);
        check("c2_busy", busy, 0);
        check_c2_keys("c2");
        @(posedge clk);
        #1;
        check("c2_done_pulse", done, 0);

        // Restart from READY with A.2
        run(KEY_A2, 0, 1'b0, '0, dc, kvl);
        check("a2_kv_dropped", kvl, 1);
        check("a2_done_cycle", dc, 46);
        check("a2_keys_valid", keys_valid, 1);
        read_rk(4'd1, v);
        check("a2_w4", v[127:96], 32'h62f8ead2);
        check("a2_w5", v[95:64], 32'h522c6b7b);
        check("a2_w6", v[63:32], 32'hfe0c91f7);
        read_rk(4'd12, v);
        check("a2_w51", v[31:0], 32'h01002202);

        // Out-of-range indices
        read_rk(4'd13, v);
        check("rk13_zero", v, 128'h0);
        read_rk(4'd15, v);
        check("rk15_zero", v, 128'h0);

        // start during EXPAND is ignored
        run(KEY_C2, 10, 1'b0, KEY_A2, dc, kvl);
        check("ign_done_cycle", dc, 46);
        check_c2_keys("ign");

        // rst mid-EXPAND then clean restart
        run(KEY_A2, 20, 1'b1, '0, dc, kvl);
        check("rst_busy", busy, 0);
        check("rst_keys_valid", keys_valid, 0);
        check("rst_done", done, 0);
        check("rst_no_done", dc, -1);
        run(KEY_C2, 0, 1'b0, '0, dc, kvl);
        check("rst_restart_done_cycle", dc, 46);
        check("rst_restart_keys_valid", keys_valid, 1);
        check_c2_keys("rst_restart");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/key_schedule_192_seq.md
# key_schedule_192_seq

Sequential AES-192 key expansion engine that sits directly upstream of the AES-192 round datapath. It accepts a 192-bit cipher key and generates the 52 expanded 32-bit words, one word per cycle. It stores them internally and exposes the 13 round keys (round 0 to round 12) through a combinational indexed read port. The round datapath reads round key k for round k and may rely on the keys only while `keys_valid` is high.

## Interface
- `NK`, 6, key length in 32-bit words
- `NB`, 4, state columns (words per round key)
- `NR`, 12, number of rounds; round keys = NR+1 = 13, total words = NB*(NR+1) = 52
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin expansion of `cipher_key`; sampled on a rising edge
- `cipher_key`  in  192  key; byte 0 in [191:184], word 0 in [191:160]
- `rk_idx`  in  4  round-key index 0..12
- `rk_data`  out  128  round key `rk_idx` = {w[4k], w[4k+1], w[4k+2], w[4k+3]}; w[4k] in [127:96]
- `busy`  out  1  expansion in progress
- `keys_valid`  out  1  all 52 words are current for the last accepted key
- `done`  out  1  one-cycle pulse when the final word is written

## Operation
- FSM states: IDLE, EXPAND, READY.
- **IDLE or READY with `start`=1:**
  - Write w[0..5] from `cipher_key` at that edge.
  - Word counter i := 6; mod-6 phase counter := 0; rcon := 8'h01.
  - `keys_valid` := 0, `busy` := 1, go to EXPAND.
- **EXPAND, each cycle, write w[i]:**
  - temp = w[i-1].
  - If phase == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon := xtime(rcon).
  - w[i] = w[i-6] ^ temp.
  - i := i+1; phase := phase+1, wrapping 5 -> 0.
- Rcon sequence across the 8 phase-0 words (i = 6, 12, …, 48): 01 02 04 08 10 20 40 80. Word 48 is the last phase-0 word, so the 0x1B reduction is never needed. A plain left shift is therefore acceptable.
- **On writing w[51]:** go to READY, `busy` := 0, `keys_valid` := 1, `done` := 1 for one cycle.
- **`start` during EXPAND:** ignored. The current expansion completes unaffected.
- **`rk_idx` > 12:** `rk_data` = 128'h0.
- **While `keys_valid` = 0:** `rk_data` is undefined to consumers; implementation returns array contents, no X-gating required.
- All arithmetic is GF(2^8) XOR; no carries. Counters wrap only as specified.

## Timing
- **Reset values:** state IDLE; `busy`=0, `keys_valid`=0, `done`=0, counters 0, rcon 8'h01. Word array contents are not reset, so `rk_data` after reset is don't-care.
- **Latency:** `start` sampled at edge E0. w[i] is written at edge E0+(i-5). w[51] is written at E0+46. `done` and `keys_valid` are high in the cycle after E0+46.
- Start-to-`keys_valid`: 46 cycles.
- `keys_valid` falls in the cycle after a restarting `start` edge.
- **`rk_data` read path:** combinational from the array and `rk_idx`, zero latency. A round key becomes readable once its four words are written, but consumers use `keys_valid` only.
- **`rst` mid-EXPAND:** next cycle is IDLE with all flags 0. A new `start` begins cleanly with no residue from the aborted run.
- **`rst` and `start` on the same edge:** `rst` wins.

## Structure
- Shared package `aes_pkg` holds:
  - the S-box constant array,
  - the `xtime` function,
  - the `word_t` (32-bit) typedef,
  - NK/NB/NR constants for the 128/192/256 variants.
- Sub-module `sub_word`: four parallel S-box lookups on one 32-bit word, combinational. It is instantiated once and shared by all phase-0 words.
- Word storage: 52 x 32 register array.

## Test plan
- **FIPS-197 C.2 key** 000102030405060708090a0b0c0d0e0f1011121314151617, pulse `start`:
  - `done` arrives exactly 46 cycles later.
  - rk_idx=1 -> 10111213141516175846f2f95c43f4fe.
  - rk_idx=12 -> a4970a331a78dc09c418c271e3a41d5d.
- **FIPS-197 A.2 key** 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - w[6] = fe0c91f7.
  - w[51] = 01002202, i.e. the low word of rk_idx=12.
- **`start` pulsed at cycle 10 of an expansion:** ignored. `done` stays at cycle 46 and keys match the first key.
- **`rst` at cycle 20 of an expansion:**
  - `busy`=0 and `keys_valid`=0 the next cycle.
  - Restarting with the C.2 key gives correct keys after 46 cycles.
- **Restart from READY with the A.2 key:** `keys_valid` drops for 46 cycles, then the A.2 round keys are readable.
- **rk_idx=13 and rk_idx=15:** `rk_data` = 0.
